// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among finished functional units,
// one registered broadcast per cycle, with tag-0 error flag and conflict counter.
module cdb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      flush,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic                      err_tag0,
    output logic [15:0]               conflict_cnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]  rr_ptr;
    logic [N_REQ-1:0]  grant_p0;
    logic [PTR_W-1:0]  gidx_p0;
    logic              found_p0;
    logic              xfer_p0;
    logic              bcast_p0;
    logic              tag0_p0;
    logic              conflict_p0;
    logic [TAG_W-1:0]  tag_p0;
    logic [DATA_W-1:0] data_p0;
    logic [PTR_W-1:0]  ptr_next;

    logic              vld_p1;
    logic [TAG_W-1:0]  tag_p1;
    logic [DATA_W-1:0] data_p1;
    logic              err_q;
    logic [15:0]       cnt_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stage p0: rotate-priority search starting at rr_ptr
    always_comb begin
        grant_p0 = '0;
        gidx_p0  = '0;
        found_p0 = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found_p0 && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                grant_p0[(int'(rr_ptr) + k) % N_REQ] = 1'b1;
                gidx_p0  = PTR_W'((int'(rr_ptr) + k) % N_REQ);
                found_p0 = 1'b1;
            end
        end
    end

    assign req_ready   = (flush || !rst_n) ? '0 : grant_p0;
    assign xfer_p0     = found_p0 && !flush && rst_n;
    assign tag_p0      = req_tag[int'(gidx_p0)*TAG_W +: TAG_W];
    assign data_p0     = req_data[int'(gidx_p0)*DATA_W +: DATA_W];
    assign bcast_p0    = xfer_p0 && (tag_p0 != '0);
    assign tag0_p0     = xfer_p0 && (tag_p0 == '0);
    assign conflict_p0 = flush ? (|req_valid) : ($countones(req_valid) > 1);
    assign ptr_next    = (int'(gidx_p0) == N_REQ - 1) ? '0 : gidx_p0 + PTR_W'(1);

    // Stage p1: registered broadcast and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            vld_p1  <= 1'b0;
            tag_p1  <= '0;
            data_p1 <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            vld_p1 <= bcast_p0;
            if (bcast_p0) begin
                tag_p1  <= tag_p0;
                data_p1 <= data_p0;
            end
            if (tag0_p0) begin
                err_q <= 1'b1;
            end
            if (conflict_p0) begin
                cnt_q <= sat_inc16(cnt_q);
            end
            if (xfer_p0) begin
                rr_ptr <= ptr_next;
            end
        end
    end

    assign cdb_valid    = vld_p1;
    assign cdb_tag      = tag_p1;
    assign cdb_data     = data_p1;
    assign err_tag0     = err_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: stimulus pushes expected broadcasts into a
// scoreboard; a negedge monitor pops and compares whenever cdb_valid is seen.
module tb_cdb_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [15:0]  req_tag;
    logic [255:0] req_data;
    logic [3:0]   req_ready;
    logic         flush;
    logic         cdb_valid;
    logic [3:0]   cdb_tag;
    logic [63:0]  cdb_data;
    logic         err_tag0;
    logic [15:0]  conflict_cnt;

    typedef struct {
        int          cyc;
        logic [3:0]  tag;
        logic [63:0] data;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    cdb_arbiter #(.N_REQ(4), .TAG_W(4), .DATA_W(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_tag      (req_tag),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .flush        (flush),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .err_tag0     (err_tag0),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] t, input logic [63:0] d);
        req_tag[i*4 +: 4]   = t;
        req_data[i*64 +: 64] = d;
    endtask

    // One arbitration cycle: apply inputs, check grant, record expected broadcast
    task automatic step(input logic [3:0] v, input logic f, input logic [3:0] exp_rdy, input string name);
        exp_t x;
        @(negedge clk);
        req_valid = v;
        flush     = f;
        #1;
        chk(name, 64'(req_ready), 64'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i] && req_tag[i*4 +: 4] != 4'd0) begin
                x.cyc  = cyc + 1;
                x.tag  = req_tag[i*4 +: 4];
                x.data = req_data[i*64 +: 64];
                sbq.push_back(x);
            end
        end
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL cdb_missing: got no broadcast in cycle %0d, expected tag %h", sbq[0].cyc, sbq[0].tag);
            void'(sbq.pop_front());
        end
        if (cdb_valid) begin
            checks++;
            if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
                errors++;
                $display("FAIL cdb_unexpected: got broadcast tag %h in cycle %0d, expected none", cdb_tag, cyc);
            end else begin
                e = sbq.pop_front();
                if (cdb_tag !== e.tag || cdb_data !== e.data) begin
                    errors++;
                    $display("FAIL cdb_payload: got tag %h data %h expected tag %h data %h",
                             cdb_tag, cdb_data, e.tag, e.data);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 4'hF;
        req_tag   = '0;
        req_data  = '0;
        set_req(0, 4'd1, 64'hA000_0000_0000_0001);
        set_req(1, 4'd2, 64'h8000_0000_0000_0002);
        set_req(2, 4'd3, 64'hFFFF_FFFF_FFFF_FFF3);
        set_req(3, 4'd4, 64'h0123_4567_89AB_CDEF);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("rst_cdb_tag", 64'(cdb_tag), 64'h0);
        chk("rst_cdb_data", cdb_data, 64'h0);
        chk("rst_err_tag0", 64'(err_tag0), 64'h0);
        chk("rst_conflict", 64'(conflict_cnt), 64'h0);
        req_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;

        // All four requesters from reset: back-to-back grants 0..3
        step(4'b1111, 1'b0, 4'b0001, "all4_g0");
        step(4'b1110, 1'b0, 4'b0010, "all4_g1");
        step(4'b1100, 1'b0, 4'b0100, "all4_g2");
        step(4'b1000, 1'b0, 4'b1000, "all4_g3");
        step(4'b0000, 1'b0, 4'b0000, "all4_idle");
        chk("all4_conflict", 64'(conflict_cnt), 64'd3);

        // Pointer wrap from requester 3 back to 0
        set_req(3, 4'd5, 64'h0000_0000_0000_DEAD);
        step(4'b1000, 1'b0, 4'b1000, "wrap_g3");
        set_req(0, 4'd6, 64'h0000_0000_0000_BEEF);
        step(4'b0001, 1'b0, 4'b0001, "wrap_g0");
        chk("wrap_data", cdb_data, 64'h0000_0000_0000_DEAD);
        step(4'b0000, 1'b0, 4'b0000, "wrap_idle");

        // Flush window blocks grants and counts as conflict
        set_req(1, 4'd7, 64'h7777_0000_7777_0000);
        step(4'b0010, 1'b1, 4'b0000, "flush_c1");
        step(4'b0010, 1'b1, 4'b0000, "flush_c2");
        step(4'b0010, 1'b0, 4'b0010, "flush_grant");
        step(4'b0000, 1'b0, 4'b0000, "flush_idle");
        chk("flush_conflict", 64'(conflict_cnt), 64'd5);

        // Tag 0 accepted silently, sticky error survives later broadcasts
        set_req(2, 4'd0, 64'h0000_0000_0000_0BAD);
        step(4'b0100, 1'b0, 4'b0100, "tag0_grant");
        step(4'b0000, 1'b0, 4'b0000, "tag0_idle");
        chk("tag0_err", 64'(err_tag0), 64'h1);
        set_req(3, 4'd9, 64'h9999_9999_9999_9999);
        step(4'b1000, 1'b0, 4'b1000, "tag0_next");
        step(4'b0000, 1'b0, 4'b0000, "tag0_idle2");
        step(4'b0000, 1'b0, 4'b0000, "hold_idle");
        chk("hold_tag", 64'(cdb_tag), 64'd9);
        chk("hold_data", cdb_data, 64'h9999_9999_9999_9999);
        chk("tag0_err_sticky", 64'(err_tag0), 64'h1);

        // Round-robin search from non-zero pointer positions
        set_req(1, 4'd10, 64'h1010_1010_1010_1010);
        set_req(2, 4'd11, 64'h1111_1111_1111_1111);
        set_req(0, 4'd12, 64'h1212_1212_1212_1212);
        step(4'b0110, 1'b0, 4'b0010, "rr_p0");
        step(4'b0100, 1'b0, 4'b0100, "rr_p2");
        step(4'b0011, 1'b0, 4'b0001, "rr_p3_wrap");
        step(4'b0010, 1'b0, 4'b0010, "rr_p1");
        step(4'b0000, 1'b0, 4'b0000, "rr_idle");
        chk("rr_conflict", 64'(conflict_cnt), 64'd7);

        // Reset while a broadcast is on the bus and requester 1 is pending
        step(4'b0011, 1'b0, 4'b0001, "prerst_g0");
        @(posedge clk);
        #2;
        chk("prerst_valid", 64'(cdb_valid), 64'h1);
        sbq.delete();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(cdb_valid), 64'h0);
        chk("midrst_tag", 64'(cdb_tag), 64'h0);
        chk("midrst_data", cdb_data, 64'h0);
        chk("midrst_err", 64'(err_tag0), 64'h0);
        chk("midrst_conflict", 64'(conflict_cnt), 64'h0);
        chk("midrst_ready", 64'(req_ready), 64'h0);
        req_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0011, 1'b0, 4'b0001, "postrst_g0");
        step(4'b0010, 1'b0, 4'b0010, "postrst_g1");
        step(4'b0000, 1'b0, 4'b0000, "postrst_idle");
        chk("postrst_conflict", 64'(conflict_cnt), 64'd1);

        // Drive the conflict counter up to saturation
        @(negedge clk);
        req_valid = 4'b0011;
        flush     = 1'b1;
        #1;
        chk("sat_flush_ready", 64'(req_ready), 64'h0);
        repeat (65533) @(posedge clk);
        #1;
        chk("sat_fffe", 64'(conflict_cnt), 64'hFFFE);
        step(4'b0011, 1'b0, 4'b0001, "sat_g0");
        step(4'b0011, 1'b0, 4'b0010, "sat_g1");
        step(4'b0011, 1'b0, 4'b0001, "sat_g0b");
        step(4'b0000, 1'b0, 4'b0000, "sat_idle");
        chk("sat_ffff", 64'(conflict_cnt), 64'hFFFF);

        repeat (3) @(negedge clk);
        #1;
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of functional-unit requesters (reservation-station groups / load buffer) sharing the CDB.
REQ-002 Parameter: TAG_W, 4, reservation-station tag width; tag 0 reserved as "no producer".
REQ-003 Parameter: DATA_W, 64, result width, matching the 64-bit register file and data memory.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: req_valid  input  N_REQ  bit i = requester i holds a finished result.
REQ-007 Port: req_tag  input  N_REQ*TAG_W  flattened; requester i at [i*TAG_W +: TAG_W].
REQ-008 Port: req_data  input  N_REQ*DATA_W  flattened; requester i at [i*DATA_W +: DATA_W].
REQ-009 Port: req_ready  output  N_REQ  one-hot or zero; bit i = requester i accepted this cycle.
REQ-010 Port: flush  input  1  squash; no grants this cycle, pending broadcast cancelled.
REQ-011 Port: cdb_valid  output  1  broadcast qualifier.
REQ-012 Port: cdb_tag  output  TAG_W  producing tag.
REQ-013 Port: cdb_data  output  DATA_W  broadcast value.
REQ-014 Port: err_tag0  output  1  sticky: a request with tag 0 was accepted.
REQ-015 Port: conflict_cnt  output  16  saturating count of cycles with an unserved valid request.

Function
REQ-016 Handshake: transfer on requester i when req_valid[i] && req_ready[i]; requester holds valid/tag/data stable until that transfer.
REQ-017 req_ready is combinational from req_valid, rr_ptr, flush; at most one bit set per cycle.
REQ-018 Grant: first i with req_valid[i] set, searching rr_ptr, rr_ptr+1, ... wrapping modulo N_REQ.
REQ-019 After a transfer on i, rr_ptr <= (i+1) mod N_REQ; with no transfer rr_ptr is unchanged.
REQ-020 rr_ptr wrap: grant to N_REQ-1 sets rr_ptr to 0.
REQ-021 Latency: a transfer in cycle t with tag != 0 gives cdb_valid=1, cdb_tag, cdb_data equal to the accepted values in cycle t+1, for exactly one cycle.
REQ-022 A cycle with no transfer drives cdb_valid=0 next cycle; cdb_tag and cdb_data hold their previous values.
REQ-023 Back-to-back transfers give one broadcast per cycle with no bubble; throughput is 1 result per cycle.
REQ-024 Tag 0 transfer: accepted (ready=1), no broadcast (cdb_valid=0 next cycle), err_tag0 set and held until reset.
REQ-025 flush=1: req_ready=0, rr_ptr unchanged, cdb_valid=0 next cycle (cancels nothing already on the bus this cycle).
REQ-026 conflict_cnt increments by 1 when flush=0 and popcount(req_valid) > 1, or when flush=1 and req_valid != 0; it saturates at 0xFFFF.
REQ-027 Data arithmetic: none; values pass unmodified, widths exact, no sign or zero extension.

Reset
REQ-028 rst_n=0 asynchronously forces cdb_valid=0, cdb_tag=0, cdb_data=0, err_tag0=0, conflict_cnt=0, rr_ptr=0.
REQ-029 During reset req_ready=0.
REQ-030 Reset mid-transfer discards the accepted result; the requester sees no completion and reissues after reset.
REQ-031 First grant after reset release follows REQ-018 from rr_ptr=0.

Verification
REQ-032 All four valid from reset (tags 1,2,3,4): ready order 0,1,2,3 on consecutive cycles -> cdb_tag 1,2,3,4 on cycles t+1..t+4, with conflict_cnt=3.
REQ-033 Only requester 3 valid (tag 5, data 0xDEAD), then only requester 0: grant 3, rr_ptr wraps to 0 -> next grant 0; cdb_data=0xDEAD one cycle after the first grant.
REQ-034 Requester 1 valid with flush=1 for 2 cycles, then flush=0: ready stays 0 for 2 cycles, then grant; conflict_cnt=2, cdb_valid=0 throughout the flush window.
REQ-035 Requester 2 has tag 0: ready=1, no cdb_valid pulse, err_tag0=1 and it stays set after later normal broadcasts.
REQ-036 rst_n low while cdb_valid=1 and requests pending: all outputs go to 0 immediately; after release the grant sequence restarts at requester 0.
REQ-037 Force conflict_cnt to 0xFFFE, then hold 2+ valid requesters: conflict_cnt reaches 0xFFFF and holds.
